pcie_rx_burst_packer: RTL and testbench
=======================================

// Module: pcie_rx_burst_packer
// PURPOSE
//  Downstream of the aurora rx data-process stage. Consumes its 64-bit rxen/rxdata word stream
//  (EDS, FBC or PMT+encoder words) and buffers it in a local FIFO.
//  Emits fixed-size bursts to the PCIe DMA write path: one header word, then BURST_LEN payload words.
//  Uses a valid/ready stream with tlast. A short final burst is flushed when the capture ends.
// PARAMETERS
//  BURST_LEN   64    payload words per full burst (power of 2, 2..1024)
//  FIFO_DEPTH  1024  local buffer depth in 64-bit words (power of 2, >= 2*BURST_LEN)
//  MAGIC       16'h5A5A  header tag, placed in header[63:48]
// PORTS
//  clk_i          in   1   aurora_log_clk_0 domain clock
//  rst_n_i        in   1   async active-low reset
//  rx_start_i     in   1   capture-start pulse, 1 cycle
//  rx_end_i       in   1   capture-end pulse, 1 cycle
//  ch_id_i        in   2   source id (0=EDS 1=FBC 2=PMT), sampled on rx_start_i
//  aurora_rxen_i  in   1   input word valid (no backpressure)
//  aurora_rxdata_i in  64  input word
//  m_tvalid_o     out  1   output word valid
//  m_tdata_o      out  64  output word
//  m_tlast_o      out  1   last word of a burst
//  m_tready_i     in   1   downstream ready
//  busy_o         out  1   high from start until the final flush completes
//  done_o         out  1   1-cycle pulse when the capture is fully drained
//  ovf_cnt_o      out  16  words dropped on FIFO full, saturating, cleared on start
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; FIFO empty; seq=0.
//  Accept: while in COLLECT/HDR/PAY/TRL with flush=0, each aurora_rxen_i word is written.
//    If the FIFO is full, the word is dropped and ovf_cnt_o is incremented (saturates at 16'hFFFF).
//  A word arriving in the same cycle as rx_end_i is accepted. Words after rx_end_i are ignored.
//  Words while IDLE are ignored.
//  rx_end_i sets flush=1 (sticky until IDLE).
//  FSM:
//    IDLE:    rx_start_i -> COLLECT; latch ch_id; clear FIFO, ovf, seq, flush.
//    COLLECT: fifo_cnt>=BURST_LEN -> HDR with len=BURST_LEN.
//             flush & fifo_cnt>0 -> HDR with len=fifo_cnt (< BURST_LEN).
//             flush & fifo_cnt==0 -> IDLE, done_o pulse.
//    HDR:     drive header; on tvalid&tready -> PAY.
//    PAY:     pop one FIFO word per handshake; rem decrements.
//             On the handshake with rem==1: m_tlast_o=1 (no TRL), go to COLLECT (or TRL), seq++.
//    TRL:     checksum word only (see CONFIGURATION); on handshake -> COLLECT.
//  Header layout: [63:48]=MAGIC, [47:46]=ch_id, [45:32]=seq (14b, wraps 3FFF->0), [31:11]=0,
//    [10:0]=len.
//  Stream rules: registered outputs. Once m_tvalid_o=1, tdata/tlast are held stable until
//    m_tready_i. tvalid never drops without a handshake, except on start-abort.
//  Latency: first header appears 2 cycles after the BURST_LEN-th word is written (FIFO read-first).
//    A fully-ready sink sustains 1 word/cycle in PAY.
//  The FIFO count stays exact when push and pop occur in the same cycle.
//  rx_start_i while not IDLE: abort. m_tvalid_o=0 next cycle (burst truncated, no tlast).
//    Then restart exactly as from IDLE.
//  rx_start_i and rx_end_i in the same cycle: start wins; end is ignored.
//  busy_o = (state!=IDLE).
//  Reset mid-burst: immediate return to reset values.
// CONFIGURATION
//  PCIE_PKT_CHKSUM_EN defined:
//    - After the last payload word, a TRL word = XOR of all payload words in the burst.
//    - m_tlast_o moves to the TRL word; header[31] = 1.
//  Not defined:
//    - No TRL state; tlast is on the last payload word; header[31] = 0.
//    - Checksum logic is absent.
// TESTING
//  1 Start ch=2, 64 words (data=i), ready=1 -> header 5A5A_8000_0000_0040, words 0..63, tlast on
//    word 63.
//  2 Start ch=0, 70 words, then end -> burst seq0 len 64, then burst seq1 len 6
//    (hdr[45:32]=1, [10:0]=6), then done_o.
//  3 Random 30% m_tready_i backpressure, 256 words -> 4 bursts; tdata stable while stalled; no loss
//    or duplication.
//  4 Sink ready=0, 1100 words -> ovf_cnt_o=76 (1100-1024); after release, exactly 1024 words out.
//  5 Start, 40 words, start again mid-burst -> m_tvalid_o low next cycle; seq restarts at 0;
//    ovf=0.
//  6 Start then end with no data -> no output words; done_o 1 cycle later; busy_o falls.
//    With PCIE_PKT_CHKSUM_EN, case 1 trailer = XOR(0..63) = 0.

Source files
------------

// File: rtl/pcie_rx_burst_packer.sv
// Packs the aurora rx word stream into header + BURST_LEN payload bursts for the PCIe DMA path.
// Optional XOR trailer per burst when PCIE_PKT_CHKSUM_EN is defined.
module pcie_rx_burst_packer #(
  parameter int          BURST_LEN  = 64,
  parameter int          FIFO_DEPTH = 1024,
  parameter logic [15:0] MAGIC      = 16'h5A5A
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_start_i,
  input  logic        rx_end_i,
  input  logic [1:0]  ch_id_i,
  input  logic        aurora_rxen_i,
  input  logic [63:0] aurora_rxdata_i,
  output logic        m_tvalid_o,
  output logic [63:0] m_tdata_o,
  output logic        m_tlast_o,
  input  logic        m_tready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] ovf_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef PCIE_PKT_CHKSUM_EN
  localparam logic CHK_FLAG = 1'b1;
`else
  localparam logic CHK_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_HDR,
    S_PAY
`ifdef PCIE_PKT_CHKSUM_EN
    , S_TRL
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [63:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic            flush;
  logic [1:0]      ch_id;
  logic [13:0]     seq;
  logic [10:0]     len, len_nxt, rem;
  logic            out_free, push, do_push, drop;
  logic            load_hdr, load_pay, load_trl, go_done;
  logic [63:0]     fifo_head;
`ifdef PCIE_PKT_CHKSUM_EN
  logic [63:0]     chk;
`endif

  // Output register follows valid/ready: once m_tvalid_o is set, data/last hold until
  // m_tready_i is seen; a new word may be loaded in the same cycle the held one is taken.
  assign out_free  = !m_tvalid_o || m_tready_i;
  assign push      = (state != S_IDLE) && !flush && aurora_rxen_i && !rx_start_i;
  assign do_push   = push && (fifo_cnt != CW'(FIFO_DEPTH));
  assign drop      = push && (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_head = mem[rd_ptr];
  assign busy_o    = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    load_hdr  = 1'b0;
    load_pay  = 1'b0;
    load_trl  = 1'b0;
    go_done   = 1'b0;
    case (state)
      S_COLLECT: begin
        if (fifo_cnt >= CW'(BURST_LEN)) begin
          len_nxt   = 11'(BURST_LEN);
          state_nxt = S_HDR;
        end else if (flush && fifo_cnt != '0) begin
          len_nxt   = 11'(fifo_cnt);
          state_nxt = S_HDR;
        end else if (flush && out_free) begin
          go_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_HDR: begin
        if (out_free) begin
          load_hdr  = 1'b1;
          state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        if (out_free) begin
          load_pay = 1'b1;
`ifdef PCIE_PKT_CHKSUM_EN
          if (rem == 11'd1) state_nxt = S_TRL;
`else
          if (rem == 11'd1) state_nxt = S_COLLECT;
`endif
        end
      end
`ifdef PCIE_PKT_CHKSUM_EN
      S_TRL: begin
        if (out_free) begin
          load_trl  = 1'b1;
          state_nxt = S_COLLECT;
        end
      end
`endif
      default: ;
    endcase
    // A start pulse in any state (re)starts the capture and wins over rx_end_i.
    if (rx_start_i) begin
      state_nxt = S_COLLECT;
      load_hdr  = 1'b0;
      load_pay  = 1'b0;
      load_trl  = 1'b0;
      go_done   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= aurora_rxdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      flush      <= 1'b0;
      ch_id      <= 2'd0;
      seq        <= 14'd0;
      len        <= 11'd0;
      rem        <= 11'd0;
      m_tvalid_o <= 1'b0;
      m_tdata_o  <= 64'd0;
      m_tlast_o  <= 1'b0;
      done_o     <= 1'b0;
      ovf_cnt_o  <= 16'd0;
`ifdef PCIE_PKT_CHKSUM_EN
      chk        <= 64'd0;
`endif
    end else begin
      done_o <= go_done;
      len    <= len_nxt;
      if (rx_start_i) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_cnt   <= '0;
        flush      <= 1'b0;
        ch_id      <= ch_id_i;
        seq        <= 14'd0;
        ovf_cnt_o  <= 16'd0;
        m_tvalid_o <= 1'b0;
        m_tlast_o  <= 1'b0;
      end else begin
        if (go_done)                                 flush <= 1'b0;
        else if (rx_end_i && state != S_IDLE)        flush <= 1'b1;
        if (do_push)                                 wr_ptr <= wr_ptr + AW'(1);
        if (load_pay)                                rd_ptr <= rd_ptr + AW'(1);
        if (drop && ovf_cnt_o != 16'hFFFF)           ovf_cnt_o <= ovf_cnt_o + 16'd1;
        case ({do_push, load_pay})
          2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
          2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
          default: ;
        endcase
        if (load_hdr) begin
          m_tvalid_o <= 1'b1;
          m_tdata_o  <= {MAGIC, ch_id, seq, CHK_FLAG, 20'd0, len};
          m_tlast_o  <= 1'b0;
          rem        <= len;
`ifdef PCIE_PKT_CHKSUM_EN
          chk        <= 64'd0;
`endif
        end else if (load_pay) begin
          m_tvalid_o <= 1'b1;
          m_tdata_o  <= fifo_head;
          rem        <= rem - 11'd1;
          if (rem == 11'd1) seq <= seq + 14'd1;
`ifdef PCIE_PKT_CHKSUM_EN
          m_tlast_o  <= 1'b0;
          chk        <= chk ^ fifo_head;
`else
          m_tlast_o  <= (rem == 11'd1);
`endif
        end else if (load_trl) begin
`ifdef PCIE_PKT_CHKSUM_EN
          m_tvalid_o <= 1'b1;
          m_tdata_o  <= chk;
          m_tlast_o  <= 1'b1;
`endif
        end else if (m_tready_i) begin
          m_tvalid_o <= 1'b0;
          m_tlast_o  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pcie_rx_burst_packer.sv
// Randomised bench for pcie_rx_burst_packer: expected burst stream is built from the accepted words.
module tb_pcie_rx_burst_packer;
  localparam int BL    = 64;
  localparam int DEPTH = 1024;
`ifdef PCIE_PKT_CHKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_start = 1'b0, rx_end = 1'b0;
  logic [1:0]  ch_id = 2'd0;
  logic        aurora_rxen = 1'b0;
  logic [63:0] aurora_rxdata = 64'd0;
  logic        m_tvalid, m_tlast, m_tready = 1'b0;
  logic [63:0] m_tdata;
  logic        busy, done;
  logic [15:0] ovf_cnt;

  pcie_rx_burst_packer #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .MAGIC(16'h5A5A)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .rx_start_i(rx_start), .rx_end_i(rx_end), .ch_id_i(ch_id),
    .aurora_rxen_i(aurora_rxen), .aurora_rxdata_i(aurora_rxdata),
    .m_tvalid_o(m_tvalid), .m_tdata_o(m_tdata), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
    .busy_o(busy), .done_o(done), .ovf_cnt_o(ovf_cnt)
  );

  // clock / reset
  initial forever #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int          checks = 0, errors = 0;
  logic [63:0] acc_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] obs_q[$];
  bit          capturing = 0;
  bit          bp_en = 0;
  int          acc_limit = 1 << 30;
  int          done_cnt = 0;
  int          stall_viol = 0;
  bit          hold_pending = 0;
  logic [64:0] hold_word;

  // sink-side monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 0;
    end else begin
      if (hold_pending && (!m_tvalid || {m_tlast, m_tdata} !== hold_word)) stall_viol++;
      hold_pending = m_tvalid && !m_tready;
      hold_word    = {m_tlast, m_tdata};
      if (m_tvalid && m_tready) obs_q.push_back({m_tlast, m_tdata});
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic cycle();
    @(posedge clk); #1;
    if (bp_en) m_tready = ($urandom_range(0, 99) >= 30);
  endtask

  task automatic do_start(input logic [1:0] ch, input logic with_end);
    rx_start = 1'b1; rx_end = with_end; ch_id = ch;
    cycle();
    rx_start = 1'b0; rx_end = 1'b0;
    acc_q.delete(); obs_q.delete();
    capturing = 1; acc_limit = 1 << 30; done_cnt = 0;
  endtask

  task automatic send_words(input int n, input int gap_pct, input bit ramp);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d;
      d = ramp ? 64'(i) : {$urandom, $urandom};
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        aurora_rxen = 1'b0;
        cycle();
      end
      aurora_rxen = 1'b1; aurora_rxdata = d;
      if (capturing && acc_q.size() < acc_limit) acc_q.push_back(d);
      cycle();
    end
    aurora_rxen = 1'b0;
  endtask

  task automatic do_end();
    rx_end = 1'b1;
    cycle();
    rx_end = 1'b0; capturing = 0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin ok = 1; break; end
      cycle();
    end
  endtask

  // reference model: chop accepted words into BL-sized bursts, remainder as a short burst
  task automatic build_expected(input logic [1:0] ch);
    int idx, seq;
    idx = 0; seq = 0;
    exp_q.delete();
    while (idx < acc_q.size()) begin
      int          len;
      logic [63:0] x;
      len = (acc_q.size() - idx >= BL) ? BL : acc_q.size() - idx;
      x = 64'd0;
      exp_q.push_back({1'b0, 16'h5A5A, ch, 14'(seq), CHK, 20'd0, 11'(len)});
      for (int k = 0; k < len; k++) begin
        x = x ^ acc_q[idx + k];
        exp_q.push_back({(!CHK && k == len - 1), acc_q[idx + k]});
      end
      if (CHK) exp_q.push_back({1'b1, x});
      idx += len;
      seq = (seq + 1) % 16384;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
    checks++; if (m_tdata !== 64'd0) begin errors++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL rst_ovf: got %0d want 0", ovf_cnt); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single_burst();
    int lat; bit ok;
    logic [63:0] hdr_want;
    hdr_want = CHK ? 64'h5A5A_8000_8000_0040 : 64'h5A5A_8000_0000_0040;
    m_tready = 1'b1; bp_en = 0;
    do_start(2'd2, 1'b0);
    send_words(BL, 0, 1'b1);
    lat = 0;
    while (!m_tvalid && lat < 10) begin cycle(); lat++; end
    checks++; if (lat != 2) begin errors++; $display("FAIL t1_hdr_latency: got %0d cycles want 2", lat); end
    do_end();
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t1_done_timeout: done_o not seen, want pulse"); end
    build_expected(2'd2);
    checks++;
    if (obs_q.size() == 0 || obs_q[0][63:0] !== hdr_want) begin
      errors++; $display("FAIL t1_header: got %h want %h", obs_q.size() ? obs_q[0][63:0] : 64'hx, hdr_want);
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t1_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL t1_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy: got %b want 0", busy); end
  endtask

  task automatic test_short_flush();
    bit ok;
    logic [63:0] d;
    m_tready = 1'b1; bp_en = 0;
    send_words(5, 0, 1'b0);
    do_start(2'd0, 1'b0);
    send_words(69, 20, 1'b0);
    d = {$urandom, $urandom};
    aurora_rxen = 1'b1; aurora_rxdata = d; acc_q.push_back(d);
    do_end();
    send_words(3, 0, 1'b0);
    wait_done(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t2_done_timeout: done_o not seen, want pulse"); end
    build_expected(2'd0);
    checks++;
    if (obs_q.size() <= BL + 1 || obs_q[BL + 1][45:32] !== 14'd1 || obs_q[BL + 1][10:0] !== 11'd6) begin
      errors++; $display("FAIL t2_hdr2: got %h want seq 1 len 6", obs_q.size() > BL + 1 ? obs_q[BL + 1][63:0] : 64'hx);
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t2_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL t2_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL t2_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    stall_viol = 0; bp_en = 1;
    do_start(2'd1, 1'b0);
    send_words(4 * BL, 10, 1'b0);
    do_end();
    wait_done(3000, ok);
    bp_en = 0; m_tready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL t3_done_timeout: done_o not seen, want pulse"); end
    build_expected(2'd1);
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL t3_stall_stable: got %0d violations want 0", stall_viol); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t3_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL t3_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    m_tready = 1'b0; bp_en = 0;
    do_start(2'd2, 1'b0);
    acc_limit = DEPTH;
    send_words(DEPTH + 76, 0, 1'b0);
    checks++; if (ovf_cnt !== 16'd76) begin errors++; $display("FAIL t4_ovf: got %0d want 76", ovf_cnt); end
    m_tready = 1'b1;
    do_end();
    wait_done(4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t4_done_timeout: done_o not seen, want pulse"); end
    build_expected(2'd2);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t4_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL t4_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort();
    bit ok;
    m_tready = 1'b0; bp_en = 0;
    do_start(2'd1, 1'b0);
    acc_limit = DEPTH;
    send_words(DEPTH + 6, 0, 1'b0);
    checks++; if (ovf_cnt !== 16'd6) begin errors++; $display("FAIL t5_ovf_pre: got %0d want 6", ovf_cnt); end
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL t5_tvalid_pre: got %b want 1", m_tvalid); end
    do_start(2'd2, 1'b0);
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL t5_tvalid_abort: got %b want 0", m_tvalid); end
    checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL t5_ovf_clear: got %0d want 0", ovf_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t5_busy: got %b want 1", busy); end
    m_tready = 1'b1;
    send_words(BL + 3, 0, 1'b0);
    do_end();
    wait_done(800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t5_done_timeout: done_o not seen, want pulse"); end
    build_expected(2'd2);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t5_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL t5_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_empty_capture();
    m_tready = 1'b1; bp_en = 0;
    do_start(2'd0, 1'b0);
    do_end();
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL t6_after_end: got done=%b busy=%b want 0/1", done, busy); end
    cycle();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL t6_done: got done=%b busy=%b want 1/0", done, busy); end
    cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t6_done_pulse: got %b want 0", done); end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL t6_no_words: got %0d words want 0", obs_q.size()); end
  endtask

  task automatic test_start_end_same();
    bit ok;
    m_tready = 1'b1; bp_en = 0;
    do_start(2'd1, 1'b1);
    repeat (3) cycle();
    checks++; if (busy !== 1'b1 || done_cnt != 0) begin errors++; $display("FAIL t7_start_wins: got busy=%b dones=%0d want 1/0", busy, done_cnt); end
    send_words(10, 30, 1'b0);
    do_end();
    wait_done(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL t7_done_timeout: done_o not seen, want pulse"); end
    build_expected(2'd1);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t7_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL t7_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    m_tready = 1'b0; bp_en = 0;
    do_start(2'd3, 1'b0);
    send_words(BL + 6, 0, 1'b0);
    checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL t8_tvalid_pre: got %b want 1", m_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || m_tdata !== 64'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL t8_async_reset: got tvalid=%b tdata=%h busy=%b want 0", m_tvalid, m_tdata, busy);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++; if (busy !== 1'b0 || ovf_cnt !== 16'd0) begin errors++; $display("FAIL t8_after_reset: got busy=%b ovf=%0d want 0", busy, ovf_cnt); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single_burst();
    test_short_flush();
    test_backpressure();
    test_overflow();
    test_abort();
    test_empty_capture();
    test_start_end_same();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
